// File: rtl/iob_fpu_normalizer_if.sv
// Start/done handshake bundle between the FPU alignment stage and the normalizer.
interface iob_fpu_normalizer_if #(
  parameter int DATA_W = 64
) ();
  localparam int LZ_W = $clog2(DATA_W + 1);

  logic              start;
  logic [DATA_W-1:0] data_in;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] data_out;
  logic [LZ_W-1:0]   lz_out;
  logic              zero;

  modport master (
    output start, data_in,
    input  busy, done, data_out, lz_out, zero
  );

  modport slave (
    input  start, data_in,
    output busy, done, data_out, lz_out, zero
  );
endinterface

// File: rtl/iob_fpu_normalizer.sv
// Chunked leading-zero scan plus left shift; latency 3..N+2 cycles from accepted start to done.
// Starts are taken only when idle (including the done cycle); a start while busy is dropped, never queued.
module iob_fpu_normalizer_clz #(
  parameter int W     = 16,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     chunk,
  output logic [CNT_W-1:0] cnt
);
  always_comb begin
    cnt = CNT_W'(W);
    for (int i = 0; i < W; i++) begin
      if (chunk[i]) cnt = CNT_W'(W - 1 - i);
    end
  end
endmodule

module iob_fpu_normalizer #(
  parameter int DATA_W  = 64,
  parameter int CHUNK_W = 16
) (
  input logic              clk,
  input logic              rst,
  iob_fpu_normalizer_if.slave io
);
  localparam int N     = DATA_W / CHUNK_W;
  localparam int LZ_W  = $clog2(DATA_W + 1);
  localparam int K_W   = (N > 1) ? $clog2(N) : 1;
  localparam int CLZ_W = $clog2(CHUNK_W + 1);

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] op_reg;
  logic [DATA_W-1:0] scanned;
  logic [DATA_W-1:0] data_out_r;
  logic [K_W-1:0]    k;
  logic [LZ_W-1:0]   lz_reg;
  logic [LZ_W-1:0]   lz_out_r;
  logic [LZ_W-1:0]   scan_off;
  logic [LZ_W-1:0]   scan_lz;
  logic [CHUNK_W-1:0] chunk;
  logic [CLZ_W-1:0]  chunk_lz;
  logic              chunk_hit;
  logic              last_chunk;
  logic              scan_end;
  logic              done_r;
  logic              zero_r;
  logic              busy_c;

  // Bring chunk k to the top of the word so one fixed slice feeds the shared clz.
  always_comb begin
    scan_off   = LZ_W'(k) * LZ_W'(CHUNK_W);
    scanned    = op_reg << scan_off;
    chunk      = scanned[DATA_W-1 -: CHUNK_W];
    chunk_hit  = |chunk;
    last_chunk = (k == K_W'(N - 1));
    scan_end   = chunk_hit || last_chunk;
    scan_lz    = scan_off + LZ_W'(chunk_lz);
  end

  iob_fpu_normalizer_clz #(
    .W     (CHUNK_W),
    .CNT_W (CLZ_W)
  ) u_clz (
    .chunk (chunk),
    .cnt   (chunk_lz)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (io.start) state_nxt = SCAN;
      SCAN:    if (scan_end) state_nxt = SHIFT;
      SHIFT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_c = (state != IDLE);
  end

  // An all-zero last chunk makes clz return CHUNK_W, so scan_lz lands on DATA_W by itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg     <= '0;
      k          <= '0;
      lz_reg     <= '0;
      data_out_r <= '0;
      lz_out_r   <= '0;
      zero_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= (state == SHIFT);
      case (state)
        IDLE: begin
          if (io.start) begin
            op_reg <= io.data_in;
            k      <= '0;
          end
        end
        SCAN: begin
          if (scan_end) lz_reg <= scan_lz;
          else          k      <= k + K_W'(1);
        end
        SHIFT: begin
          data_out_r <= op_reg << lz_reg;
          lz_out_r   <= lz_reg;
          zero_r     <= (lz_reg == LZ_W'(DATA_W));
        end
        default: ;
      endcase
    end
  end

  assign io.busy     = busy_c;
  assign io.done     = done_r;
  assign io.data_out = data_out_r;
  assign io.lz_out   = lz_out_r;
  assign io.zero     = zero_r;
endmodule
